// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine.
// Turns the EX/MEM register outputs into a single req/ack data-memory
// access with byte-lane write enables and load extension. The pipeline is
// stalled through mem_busy while the access is in flight, and the result is
// held in DONE until the MEM-stage register advances.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_Memread,
  input  logic        MEM_Memwrite,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] MEM_forward_rs2_data,
  input  logic        pipe_adv,
  output logic        mem_busy,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Timeout counter, cleared whenever a new access is launched.
  logic [CNT_W-1:0] cnt;

  // Attributes of the in-flight access, captured at launch so the load
  // extraction does not depend on the (stalled) pipeline inputs.
  logic        op_load;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;

  logic        any_op;
  logic        op_legal;
  logic        timeout_hit;

  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ld_ext;

  assign any_op      = MEM_Memread | MEM_Memwrite;
  assign timeout_hit = (state == ACCESS) && !dm_ack && (cnt == CNT_W'(TIMEOUT - 1));

  // Decide whether the requested operation is legal (encoding and alignment).
  always_comb begin
    op_legal = 1'b0;
    if (MEM_Memread && MEM_Memwrite) begin
      op_legal = 1'b0;
    end else if (MEM_Memread) begin
      case (MEM_funct3)
        3'b000, 3'b100: op_legal = 1'b1;
        3'b001, 3'b101: op_legal = ~MEM_alu_out[0];
        3'b010:         op_legal = (MEM_alu_out[1:0] == 2'b00);
        default:        op_legal = 1'b0;
      endcase
    end else if (MEM_Memwrite) begin
      case (MEM_funct3)
        3'b000:  op_legal = 1'b1;
        3'b001:  op_legal = ~MEM_alu_out[0];
        3'b010:  op_legal = (MEM_alu_out[1:0] == 2'b00);
        default: op_legal = 1'b0;
      endcase
    end
  end

  // Build store byte enables and lane-replicated store data.
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = MEM_forward_rs2_data;
    case (MEM_funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << MEM_alu_out[1:0];
        st_wdata = {4{MEM_forward_rs2_data[7:0]}};
      end
      2'b01: begin
        st_we    = MEM_alu_out[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{MEM_forward_rs2_data[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = MEM_forward_rs2_data;
      end
    endcase
  end

  // Split the read word into byte lanes for the byte-load mux.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_byte[gi] = dm_rdata[8*gi +: 8];
    end
  endgenerate

  // Extract and sign/zero-extend the loaded value for the captured access.
  always_comb begin
    sel_byte = rd_byte[op_off];
    sel_half = op_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_f3)
      3'b000:  ld_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ld_ext = {24'd0, sel_byte};
      3'b001:  ld_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  ld_ext = {16'd0, sel_half};
      default: ld_ext = dm_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: illegal ops skip ACCESS and go straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_op) begin
          state_next = op_legal ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (dm_ack || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (pipe_adv) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall output: any pending op holds the pipe until DONE is reached.
  always_comb begin
    mem_busy = 1'b0;
    case (state)
      IDLE:    mem_busy = any_op;
      ACCESS:  mem_busy = 1'b1;
      default: mem_busy = 1'b0;
    endcase
  end

  // Registered bus signals, result registers, error pulse and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      dm_req     <= 1'b0;
      dm_addr    <= 32'd0;
      dm_we      <= 4'b0000;
      dm_wdata   <= 32'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      mem_err    <= 1'b0;
      op_load    <= 1'b0;
      op_f3      <= 3'b000;
      op_off     <= 2'b00;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_op) begin
            cnt <= '0;
            if (op_legal) begin
              dm_req   <= 1'b1;
              dm_addr  <= {MEM_alu_out[31:2], 2'b00};
              dm_we    <= MEM_Memwrite ? st_we : 4'b0000;
              dm_wdata <= MEM_Memwrite ? st_wdata : 32'd0;
              op_load  <= MEM_Memread;
              op_f3    <= MEM_funct3;
              op_off   <= MEM_alu_out[1:0];
            end else begin
              mem_err    <= 1'b1;
              load_data  <= 32'd0;
              load_valid <= MEM_Memread;
            end
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 4'b0000;
            if (op_load) begin
              load_data  <= ld_ext;
              load_valid <= 1'b1;
            end
          end else if (timeout_hit) begin
            dm_req     <= 1'b0;
            dm_we      <= 4'b0000;
            mem_err    <= 1'b1;
            load_data  <= 32'd0;
            load_valid <= op_load;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (pipe_adv) begin
            load_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven and randomized checks of mem_access_unit
// against a behavioural model of the load/store rules.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Memread;
  logic        MEM_Memwrite;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_alu_out;
  logic [31:0] MEM_forward_rs2_data;
  logic        pipe_adv;
  logic        mem_busy;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .MEM_Memread(MEM_Memread), .MEM_Memwrite(MEM_Memwrite),
    .MEM_funct3(MEM_funct3), .MEM_alu_out(MEM_alu_out),
    .MEM_forward_rs2_data(MEM_forward_rs2_data), .pipe_adv(pipe_adv),
    .mem_busy(mem_busy), .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .load_data(load_data), .load_valid(load_valid), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // One access: inputs, memory behaviour (delay<0 = never ack) and expectations.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          delay;
    logic        ill;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int delay, input logic ill,
                              input logic [3:0] we, input logic [31:0] wdata,
                              input logic [31:0] ld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.delay = delay; v.ill = ill; v.we = we; v.wdata = wdata; v.ld = ld;
    return v;
  endfunction

  // Reference model: access width in bytes, alignment by modulo, lanes by
  // byte position, extension by masking and OR-ing the upper bits.
  function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic [31:0] rdata, input int delay);
    vec_t v;
    int nbytes;
    int off;
    logic [31:0] mask;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.delay = delay;
    nbytes = 1 << f3[1:0];
    off = int'(addr % 4);
    v.ill = 1'b0;
    if (rd && wr) v.ill = 1'b1;
    else if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) v.ill = 1'b1;
    else if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) v.ill = 1'b1;
    if (!v.ill && (off % nbytes) != 0) v.ill = 1'b1;
    v.we = 4'b0000;
    v.wdata = 32'd0;
    if (wr && !v.ill) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nbytes) v.we[i] = 1'b1;
        v.wdata[8*i +: 8] = rs2[8*(i % nbytes) +: 8];
      end
    end
    v.ld = 32'd0;
    if (rd && !v.ill && delay >= 0) begin
      if (nbytes == 4) begin
        v.ld = rdata;
      end else begin
        mask = (32'd1 << (8*nbytes)) - 32'd1;
        v.ld = (rdata >> (8*off)) & mask;
        if (!f3[2] && v.ld[8*nbytes-1]) v.ld = v.ld | ~mask;
      end
    end
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn %0d: got %h want %h", nm, tag, act, exp);
    end
  endtask

  // Drive one access through detect, ACCESS, DONE and back to IDLE.
  task automatic do_op(input vec_t v, input int tag);
    int          req_cycles;
    int          busy_cycles;
    int          exp_len;
    logic        stable_bad;
    logic        exp_err;
    logic [31:0] exp_addr;
    exp_err     = v.ill || (v.delay < 0);
    exp_len     = (v.delay < 0) ? TIMEOUT : v.delay + 1;
    exp_addr    = {v.addr[31:2], 2'b00};
    stable_bad  = 1'b0;
    req_cycles  = 0;
    busy_cycles = 0;
    @(negedge clk);
    MEM_Memread = v.rd; MEM_Memwrite = v.wr; MEM_funct3 = v.f3;
    MEM_alu_out = v.addr; MEM_forward_rs2_data = v.rs2; dm_rdata = v.rdata;
    dm_ack = 1'b0; pipe_adv = 1'b0;
    #1;
    if (!v.ill) begin
      chk("busy_detect", tag, 32'(mem_busy), 32'd1);
      if (mem_busy === 1'b1) busy_cycles++;
    end
    @(posedge clk); #1;
    if (v.ill) begin
      chk("no_req_illegal", tag, 32'(dm_req), 32'd0);
    end else begin
      chk("req_start", tag, 32'(dm_req), 32'd1);
      chk("dm_addr", tag, dm_addr, exp_addr);
      chk("dm_we", tag, 32'(dm_we), 32'(v.we));
      if (v.wr) chk("dm_wdata", tag, dm_wdata, v.wdata);
      while (dm_req === 1'b1 && req_cycles < TIMEOUT + 4) begin
        if (dm_addr !== exp_addr || dm_we !== v.we || (v.wr && dm_wdata !== v.wdata))
          stable_bad = 1'b1;
        if (mem_busy === 1'b1) busy_cycles++;
        req_cycles++;
        dm_ack = (v.delay >= 0) && (req_cycles - 1 == v.delay);
        @(posedge clk); #1;
        dm_ack = 1'b0;
      end
      chk("req_len", tag, 32'(req_cycles), 32'(exp_len));
      chk("req_stable", tag, 32'(stable_bad), 32'd0);
      chk("busy_total", tag, 32'(busy_cycles), 32'(exp_len + 1));
      chk("we_cleared", tag, 32'(dm_we), 32'd0);
    end
    chk("done_busy", tag, 32'(mem_busy), 32'd0);
    chk("err_pulse", tag, 32'(mem_err), 32'(exp_err));
    chk("load_valid", tag, 32'(load_valid), 32'(v.rd));
    if (v.rd) chk("load_data", tag, load_data, v.ld);
    @(posedge clk); #1;
    chk("err_single", tag, 32'(mem_err), 32'd0);
    chk("lv_hold", tag, 32'(load_valid), 32'(v.rd));
    if (v.rd) chk("ld_hold", tag, load_data, v.ld);
    pipe_adv = 1'b1;
    @(posedge clk); #1;
    pipe_adv = 1'b0; MEM_Memread = 1'b0; MEM_Memwrite = 1'b0;
    #1;
    chk("lv_clear", tag, 32'(load_valid), 32'd0);
    chk("idle_busy", tag, 32'(mem_busy), 32'd0);
    $display("txn %0d rd=%0b wr=%0b f3=%03b addr=%h rs2=%h rdata=%h delay=%0d req_cycles=%0d ld=%h",
             tag, v.rd, v.wr, v.f3, v.addr, v.rs2, v.rdata, v.delay, req_cycles, load_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_rd;
    logic        r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          pick;
    int          dl;

    //            rd wr f3      addr          rs2           rdata         dly ill we       wdata         ld
    tbl[0]  = mk(0, 1, 3'b010, 32'h0000_1004, 32'hDEADBEEF, 32'h0,         0, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(0, 1, 3'b000, 32'h0000_1003, 32'h000000A5, 32'h0,         0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0);
    tbl[2]  = mk(1, 0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 0, 4'b0000, 32'h0,        32'h0000_0080);
    tbl[3]  = mk(1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FF80);
    tbl[4]  = mk(1, 0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_7FFF, 5, 0, 4'b0000, 32'h0,        32'hFFFF_8001);
    tbl[5]  = mk(1, 0, 3'b101, 32'h0000_2000, 32'h0,        32'h8001_7FFF, 2, 0, 4'b0000, 32'h0,        32'h0000_7FFF);
    tbl[6]  = mk(1, 0, 3'b010, 32'h0000_3001, 32'h0,        32'h1111_1111, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[7]  = mk(0, 1, 3'b001, 32'h0000_0010, 32'h12345678, 32'h0,         0, 0, 4'b0011, 32'h56785678, 32'h0);
    tbl[8]  = mk(0, 1, 3'b001, 32'h0000_0012, 32'h0000BEEF, 32'h0,         3, 0, 4'b1100, 32'hBEEFBEEF, 32'h0);
    tbl[9]  = mk(1, 0, 3'b010, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 3, 0, 4'b0000, 32'h0,        32'hCAFE_F00D);
    tbl[10] = mk(1, 0, 3'b010, 32'h0000_5000, 32'h0,        32'h2222_2222, -1, 0, 4'b0000, 32'h0,       32'h0);
    tbl[11] = mk(1, 1, 3'b010, 32'h0000_6000, 32'h3,        32'h3333_3333, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[12] = mk(1, 0, 3'b011, 32'h0000_6008, 32'h0,        32'h4444_4444, 0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[13] = mk(0, 1, 3'b100, 32'h0000_600C, 32'h5,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[14] = mk(1, 0, 3'b000, 32'h0000_7001, 32'h0,        32'h0000_7F00, 0, 0, 4'b0000, 32'h0,        32'h0000_007F);
    tbl[15] = mk(0, 1, 3'b001, 32'h0000_0001, 32'h6,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
    tbl[16] = mk(0, 1, 3'b010, 32'h0000_8000, 32'h11223344, 32'h0,        -1, 0, 4'b1111, 32'h11223344, 32'h0);

    rst = 1'b0; MEM_Memread = 1'b0; MEM_Memwrite = 1'b0; MEM_funct3 = 3'b000;
    MEM_alu_out = 32'd0; MEM_forward_rs2_data = 32'd0; pipe_adv = 1'b0;
    dm_ack = 1'b0; dm_rdata = 32'd0;
    #1;
    chk("rst_req", 0, 32'(dm_req), 32'd0);
    chk("rst_addr", 0, dm_addr, 32'd0);
    chk("rst_we", 0, 32'(dm_we), 32'd0);
    chk("rst_wdata", 0, dm_wdata, 32'd0);
    chk("rst_ld", 0, load_data, 32'd0);
    chk("rst_lv", 0, 32'(load_valid), 32'd0);
    chk("rst_err", 0, 32'(mem_err), 32'd0);
    chk("rst_busy", 0, 32'(mem_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // No operation: stays idle, never requests.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("noop_req", 0, 32'(dm_req), 32'd0);
      chk("noop_busy", 0, 32'(mem_busy), 32'd0);
    end

    for (int i = 0; i < 17; i++) begin
      do_op(tbl[i], i + 1);
    end

    // Reset in the middle of ACCESS clears everything without a clock edge.
    do_op(tbl[9], 50);
    @(negedge clk);
    MEM_Memwrite = 1'b1; MEM_funct3 = 3'b010; MEM_alu_out = 32'h0000_9008;
    MEM_forward_rs2_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    chk("pre_rst_req", 51, 32'(dm_req), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 51, 32'(dm_req), 32'd0);
    chk("mid_rst_addr", 51, dm_addr, 32'd0);
    chk("mid_rst_we", 51, 32'(dm_we), 32'd0);
    chk("mid_rst_wdata", 51, dm_wdata, 32'd0);
    chk("mid_rst_ld", 51, load_data, 32'd0);
    chk("mid_rst_lv", 51, 32'(load_valid), 32'd0);
    chk("mid_rst_err", 51, 32'(mem_err), 32'd0);
    MEM_Memwrite = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op(tbl[0], 52);

    // Randomized accesses checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 9));
      r_rd = (pick < 4) || (pick == 8) || (pick == 9);
      r_wr = (pick >= 4 && pick < 8) || (pick == 8);
      if ($urandom_range(0, 3) != 0) begin
        if (r_wr && !r_rd) begin
          r_f3 = 3'($urandom_range(0, 2));
        end else begin
          pick = int'($urandom_range(0, 4));
          r_f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
        end
      end else begin
        r_f3 = 3'($urandom_range(0, 7));
      end
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
        if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
      end
      dl = int'($urandom_range(0, 11));
      dl = (dl == 11) ? -1 : dl % 5;
      do_op(model(r_rd, r_wr, r_f3, r_addr, $urandom, $urandom, dl), 100 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine; consumes the EX/MEM pipeline register outputs (MEM_Memread, MEM_Memwrite, MEM_funct3, MEM_alu_out, MEM_forward_rs2_data).
- Drives a variable-latency data-memory req/ack interface, with byte-lane write enables and load sign/zero extension.
- Holds the pipeline through mem_busy until the access completes.

Parameters:
- TIMEOUT, 16: ACCESS cycles without dm_ack before bus error (≥2).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- MEM_Memread  input  1  load in MEM stage
- MEM_Memwrite  input  1  store in MEM stage
- MEM_funct3  input  3  access size/sign
- MEM_alu_out  input  32  byte address
- MEM_forward_rs2_data  input  32  store data
- pipe_adv  input  1  MEM-stage register advances this cycle
- mem_busy  output  1  stall request to hazard unit
- dm_req  output  1  memory request
- dm_addr  output  32  word address: {alu_out[31:2],2'b00}
- dm_we  output  4  byte write enables; 0 for loads
- dm_wdata  output  32  lane-replicated store data
- dm_ack  input  1  memory completion
- dm_rdata  input  32  read word, valid with dm_ack
- load_data  output  32  extended load result
- load_valid  output  1  load_data valid
- mem_err  output  1  one-cycle pulse on misalign, illegal op, or timeout

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0. All outputs 0: dm_req, dm_addr, dm_we, dm_wdata, load_data, load_valid, mem_err. A reset during ACCESS drops dm_req immediately.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE with Memread|Memwrite and a legal op: mem_busy=1 combinationally in the same cycle. Next edge: register dm_addr, dm_we, dm_wdata; set dm_req=1; go to ACCESS.
- IDLE with an illegal op: no request. Next edge: mem_err=1 for one cycle, load_data=0, load_valid=Memread; go to DONE.
- Illegal ops:
  - Memread&Memwrite both set.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- ACCESS:
  - mem_busy=1. dm_req, dm_addr, dm_we, dm_wdata are held stable until the ack edge.
  - On dm_ack: dm_req=0, dm_we=0; for loads, register the extended load_data and set load_valid=1; go to DONE.
  - Counter increments each ACCESS cycle without ack. At TIMEOUT: dm_req=0, mem_err pulse, load_data=0, load_valid=Memread; go to DONE.
- DONE:
  - mem_busy=0; load_data/load_valid are held.
  - On pipe_adv: go to IDLE and clear load_valid. The next instruction is evaluated in IDLE the following cycle, never back-to-back from DONE.
  - pipe_adv is ignored in IDLE and ACCESS.
- Store lanes (a=addr[1:0]):
  - SB: we=4'b0001<<a, wdata={4{rs2[7:0]}}.
  - SH: we=a[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - SW: we=1111, wdata=rs2.
- Load extraction:
  - LB/LBU: byte rdata[8a+7:8a], sign- or zero-extended.
  - LH/LHU: half rdata[16a[1]+15:16a[1]], sign- or zero-extended.
  - LW: rdata.
- Minimum latency: detect cycle 0 → dm_req cycle 1 → ack in cycle 1 → DONE/load_valid cycle 2. Total mem_busy = 2 cycles.
- Neither Memread nor Memwrite set: stay IDLE with mem_busy=0.

Test Plan:
- SW: addr=0x0000_1004, rs2=0xDEADBEEF, ack 1 cycle after req → dm_addr=0x1004, dm_we=1111, dm_wdata=0xDEADBEEF; mem_busy high for exactly 2 cycles; no load_valid.
- SB and LBU at addr=0x1003: SB with rs2=0x000000A5 → dm_we=1000, dm_wdata=0xA5A5A5A5. LBU with dm_rdata=0x80FF_1234 → load_data=0x0000_0080. LB at the same address → load_data=0xFFFF_FF80.
- LH: addr=0x2002, dm_rdata=0x8001_7FFF, ack delayed 5 cycles → dm_req held 6 cycles with stable addr, load_data=0xFFFF_8001, load_valid held until pipe_adv.
- Misaligned LW at addr=0x3001 → dm_req never asserted, mem_err single pulse, load_data=0, load_valid=1, DONE.
- No ack, TIMEOUT=16 → dm_req high 16 cycles then low, mem_err pulse, FSM reaches DONE, then IDLE on pipe_adv.
- Reset asserted mid-ACCESS → dm_req=0 and all outputs 0 without a clock edge; after release, a new SW completes normally.
